// File: rtl/decode_pkg.sv
// decode_pkg: shared types for the decode stage.
//   f_d_WI  - fetch -> decode registered bundle (instruction address)
//   w_d_WI  - writeback -> decode bundle (register write, jump-taken flush)
//   d_e_WI  - decode -> execute registered bundle
//   op_cls_e, dec_state_e, RV32I opcode constants, immediate helpers.
package decode_pkg;

  typedef enum logic [3:0] {
    OC_LUI    = 4'd0,
    OC_AUIPC  = 4'd1,
    OC_JAL    = 4'd2,
    OC_JALR   = 4'd3,
    OC_BRANCH = 4'd4,
    OC_LOAD   = 4'd5,
    OC_STORE  = 4'd6,
    OC_OP_IMM = 4'd7,
    OC_OP     = 4'd8,
    OC_MISC   = 4'd9
  } op_cls_e;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } dec_state_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [31:0] instr_addr;
  } f_d_WI;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] rd_dat;
    logic        jmp_tk;
  } w_d_WI;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_dat;
    logic [31:0] rs2_dat;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    op_cls_e     op_cls;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        is_load;
    logic        rd_we;
    logic        illegal;
  } d_e_WI;

  // Immediate extraction, sign-extended to 32 bits.
  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/d_register.sv
// d_register: generic pipeline register.
//   clk, rst_n (sync, active-low) - clock and reset (clears to zero)
//   en    - load enable
//   flush - load zeros (bubble), overrides en
//   d, q  - W-bit data in / registered data out
module d_register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Pipeline register with synchronous clear and bubble insertion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (flush) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/decode_reg_file.sv
// reg_file: 32x32 integer register file, two combinational read ports and
// one synchronous write port. x0 reads as zero, writes to x0 are dropped.
//   BYPASS     - 1: a same-cycle write to the read register returns write data
//   clk        - clock
//   we, wa, wd - write enable / address / data
//   ra1, rd1   - read port 1 address / data
//   ra2, rd2   - read port 2 address / data
module reg_file #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2
);

  // Contents are intentionally not reset.
  logic [31:0] mem_r [0:31];

  // Write port
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      mem_r[wa] <= wd;
    end
  end

  // Read port 1 with optional write-through
  always_comb begin
    rd1 = 32'h0000_0000;
    if (ra1 == 5'd0) begin
      rd1 = 32'h0000_0000;
    end else if (BYPASS && we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = mem_r[ra1];
    end
  end

  // Read port 2 with optional write-through
  always_comb begin
    rd2 = 32'h0000_0000;
    if (ra2 == 5'd0) begin
      rd2 = 32'h0000_0000;
    end else if (BYPASS && we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = mem_r[ra2];
    end
  end

endmodule

// File: rtl/decode.sv
// decode: second pipeline stage. Decodes RV32I, reads the register file,
// builds immediates, detects load-use hazards and registers the execute bundle.
//   RF_BYPASS    - register file write-through on same-cycle read
//   clk, rst_n   - clock, synchronous active-low reset
//   f_in         - fetch bundle (instruction address)
//   instr_dat_in - instruction word aligned with f_in
//   stall_in     - fetch bubble: f_in/instr_dat_in invalid this cycle
//   w_in         - writeback bundle (rf write, jump-taken flush)
//   d_out        - registered decode bundle for execute
//   hold_out     - combinational PC stall, high in the load-use detect cycle
module decode
  import decode_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  f_d_WI       f_in,
  input  logic [31:0] instr_dat_in,
  input  logic        stall_in,
  input  w_d_WI       w_in,
  output d_e_WI       d_out,
  output logic        hold_out
);

  dec_state_e state_r;
  dec_state_e state_nx_s;

  logic        in_v_s;
  logic        haz_s;
  logic        bubble_s;

  op_cls_e     cls_s;
  logic [31:0] imm_s_s;
  logic        rs1_use_s;
  logic        rs2_use_s;
  logic        wr_s;
  logic        is_load_s;
  logic        illegal_s;

  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [4:0]  rd_s;
  logic [31:0] rs1_dat_s;
  logic [31:0] rs2_dat_s;

  d_e_WI                     dec_s;
  logic [$bits(d_e_WI)-1:0]  d_q_s;

  assign rs1_s = instr_dat_in[19:15];
  assign rs2_s = instr_dat_in[24:20];
  assign rd_s  = instr_dat_in[11:7];

  reg_file #(
    .BYPASS (RF_BYPASS)
  ) u_reg_file (
    .clk (clk),
    .we  (w_in.rf_we),
    .wa  (w_in.rd),
    .wd  (w_in.rd_dat),
    .ra1 (rs1_s),
    .rd1 (rs1_dat_s),
    .ra2 (rs2_s),
    .rd2 (rs2_dat_s)
  );

  // Opcode decode: class, immediate format, register usage, write-back flag.
  // Every legal opcode constant ends in 2'b11, so a bad [1:0] lands in default.
  always_comb begin
    cls_s     = OC_MISC;
    imm_s_s   = 32'h0000_0000;
    rs1_use_s = 1'b0;
    rs2_use_s = 1'b0;
    wr_s      = 1'b0;
    is_load_s = 1'b0;
    illegal_s = 1'b0;
    case (instr_dat_in[6:0])
      OPC_LUI: begin
        cls_s   = OC_LUI;
        imm_s_s = imm_u(instr_dat_in);
        wr_s    = 1'b1;
      end
      OPC_AUIPC: begin
        cls_s   = OC_AUIPC;
        imm_s_s = imm_u(instr_dat_in);
        wr_s    = 1'b1;
      end
      OPC_JAL: begin
        cls_s   = OC_JAL;
        imm_s_s = imm_j(instr_dat_in);
        wr_s    = 1'b1;
      end
      OPC_JALR: begin
        cls_s     = OC_JALR;
        imm_s_s   = imm_i(instr_dat_in);
        rs1_use_s = 1'b1;
        wr_s      = 1'b1;
      end
      OPC_BRANCH: begin
        cls_s     = OC_BRANCH;
        imm_s_s   = imm_b(instr_dat_in);
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
      end
      OPC_LOAD: begin
        cls_s     = OC_LOAD;
        imm_s_s   = imm_i(instr_dat_in);
        rs1_use_s = 1'b1;
        wr_s      = 1'b1;
        is_load_s = 1'b1;
      end
      OPC_STORE: begin
        cls_s     = OC_STORE;
        imm_s_s   = imm_s(instr_dat_in);
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
      end
      OPC_OP_IMM: begin
        cls_s     = OC_OP_IMM;
        imm_s_s   = imm_i(instr_dat_in);
        rs1_use_s = 1'b1;
        wr_s      = 1'b1;
      end
      OPC_OP: begin
        cls_s     = OC_OP;
        rs1_use_s = 1'b1;
        rs2_use_s = 1'b1;
        wr_s      = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        cls_s = OC_MISC;
      end
      default: begin
        cls_s     = OC_MISC;
        illegal_s = 1'b1;
      end
    endcase
  end

  assign in_v_s = ~stall_in & ~w_in.jmp_tk & (state_r == ST_RUN);

  // Load-use: the load now in d_out targets a register this instruction reads.
  assign haz_s = in_v_s & d_out.valid & d_out.is_load & (d_out.rd != 5'd0) &
                 ((rs1_use_s & (rs1_s == d_out.rd)) |
                  (rs2_use_s & (rs2_s == d_out.rd)));

  // Reset gates hold so a hazard seen during reset never stalls the PC.
  assign hold_out = rst_n & haz_s;

  assign bubble_s = w_in.jmp_tk | haz_s | (state_r == ST_BUBBLE);

  // Assemble the bundle handed to the pipeline register
  always_comb begin
    dec_s          = {$bits(d_e_WI){1'b0}};
    dec_s.valid    = in_v_s;
    dec_s.pc       = f_in.instr_addr;
    dec_s.pc4      = f_in.instr_addr + 32'd4;
    dec_s.rs1_dat  = rs1_dat_s;
    dec_s.rs2_dat  = rs2_dat_s;
    dec_s.imm      = imm_s_s;
    dec_s.rs1      = rs1_s;
    dec_s.rs2      = rs2_s;
    dec_s.rd       = rd_s;
    dec_s.op_cls   = cls_s;
    dec_s.funct3   = instr_dat_in[14:12];
    dec_s.funct7b5 = instr_dat_in[30];
    dec_s.is_load  = is_load_s;
    dec_s.rd_we    = wr_s & ~illegal_s & (rd_s != 5'd0);
    dec_s.illegal  = illegal_s;
  end

  d_register #(
    .W ($bits(d_e_WI))
  ) u_d_register (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .flush (bubble_s),
    .d     (dec_s),
    .q     (d_q_s)
  );

  assign d_out = d_e_WI'(d_q_s);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: a hazard costs one BUBBLE cycle; a flush always returns to RUN
  always_comb begin
    state_nx_s = ST_RUN;
    case (state_r)
      ST_RUN: begin
        if (w_in.jmp_tk) begin
          state_nx_s = ST_RUN;
        end else if (haz_s) begin
          state_nx_s = ST_BUBBLE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_BUBBLE: begin
        state_nx_s = ST_RUN;
      end
      default: begin
        state_nx_s = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed and randomized checks of decode against a behavioural
// model. Two instances run side by side, one with and one without RF bypass.
module tb_decode;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  f_d_WI       f_in;
  logic [31:0] instr_dat;
  logic        stall_in;
  w_d_WI       w_in;
  d_e_WI       d_b, d_nb;
  logic        hold_b, hold_nb;

  always #5 clk = ~clk;

  decode #(.RF_BYPASS(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .f_in(f_in), .instr_dat_in(instr_dat),
    .stall_in(stall_in), .w_in(w_in), .d_out(d_b), .hold_out(hold_b));

  decode #(.RF_BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .f_in(f_in), .instr_dat_in(instr_dat),
    .stall_in(stall_in), .w_in(w_in), .d_out(d_nb), .hold_out(hold_nb));

  int checks_r = 0;
  int errors_r = 0;

  // model state
  d_e_WI       m_d_b, m_d_nb;
  bit          m_bub;
  logic [31:0] m_rf [32];
  logic        obs_hold;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit uses_rs1(input logic [6:0] op);
    return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {7'h63, 7'h23, 7'h33};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && w_in.rf_we && (w_in.rd == a)) return w_in.rd_dat;
    return m_rf[a];
  endfunction

  // RV32I decode from the ISA rules, immediates built with shifts and masks
  function automatic d_e_WI model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2,
                                         input logic v);
    d_e_WI b;
    logic signed [31:0] si;
    logic [31:0] hi;
    bit wr;
    si = $signed(ins);
    b = '0;
    wr = 1'b0;
    b.valid = v; b.pc = pc; b.pc4 = pc + 32'd4;
    b.rs1_dat = r1; b.rs2_dat = r2;
    b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
    b.funct3 = ins[14:12]; b.funct7b5 = ins[30];
    b.op_cls = OC_MISC;
    case (ins[6:0])
      7'h37: begin b.op_cls = OC_LUI;   b.imm = ins & 32'hFFFFF000; wr = 1'b1; end
      7'h17: begin b.op_cls = OC_AUIPC; b.imm = ins & 32'hFFFFF000; wr = 1'b1; end
      7'h6F: begin
        b.op_cls = OC_JAL; hi = si >>> 31;
        b.imm = (hi << 20) | (ins & 32'h000FF000) | (((ins >> 20) & 32'h1) << 11)
              | (((ins >> 21) & 32'h3FF) << 1);
        wr = 1'b1;
      end
      7'h67: begin b.op_cls = OC_JALR; hi = si >>> 20; b.imm = hi; wr = 1'b1; end
      7'h63: begin
        b.op_cls = OC_BRANCH; hi = si >>> 31;
        b.imm = (hi << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5)
              | (((ins >> 8) & 32'hF) << 1);
      end
      7'h03: begin b.op_cls = OC_LOAD; hi = si >>> 20; b.imm = hi; wr = 1'b1; b.is_load = 1'b1; end
      7'h23: begin b.op_cls = OC_STORE; hi = si >>> 25; b.imm = (hi << 5) | ((ins >> 7) & 32'h1F); end
      7'h13: begin b.op_cls = OC_OP_IMM; hi = si >>> 20; b.imm = hi; wr = 1'b1; end
      7'h33: begin b.op_cls = OC_OP; wr = 1'b1; end
      7'h0F, 7'h73: b.op_cls = OC_MISC;
      default: b.illegal = 1'b1;
    endcase
    b.rd_we = wr && (b.rd != 5'd0);
    return b;
  endfunction

  // One clock: drive at negedge, check hold, predict, check d_out after posedge
  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                      input logic stl, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic jmp);
    bit in_v, haz;
    logic [31:0] r1b, r2b, r1n, r2n;
    @(negedge clk);
    rst_n = rst; instr_dat = ins; f_in.instr_addr = pc; stall_in = stl;
    w_in.rf_we = we; w_in.rd = wr; w_in.rd_dat = wd; w_in.jmp_tk = jmp;
    #1;
    in_v = !stl && !jmp && !m_bub;
    haz = in_v && m_d_b.valid && m_d_b.is_load && (m_d_b.rd != 5'd0) &&
          ((uses_rs1(ins[6:0]) && ins[19:15] == m_d_b.rd) ||
           (uses_rs2(ins[6:0]) && ins[24:20] == m_d_b.rd));
    obs_hold = hold_b;
    chk("hold_out", hold_b, rst && haz);
    chk("hold_out_nb", hold_nb, rst && haz);
    r1b = m_read(ins[19:15], 1'b1); r2b = m_read(ins[24:20], 1'b1);
    r1n = m_read(ins[19:15], 1'b0); r2n = m_read(ins[24:20], 1'b0);
    if (!rst) begin
      m_d_b = '0; m_d_nb = '0; m_bub = 1'b0;
    end else if (jmp || haz || m_bub) begin
      m_d_b = '0; m_d_nb = '0; m_bub = haz;
    end else begin
      m_d_b  = model_decode(ins, pc, r1b, r2b, in_v);
      m_d_nb = model_decode(ins, pc, r1n, r2n, in_v);
      m_bub  = 1'b0;
    end
    if (we && wr != 5'd0) m_rf[wr] = wd;
    @(posedge clk);
    #1;
    chk("d_out", d_b, m_d_b);
    chk("d_out_nb", d_nb, m_d_nb);
  endtask

  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD3 = 32'h000101B3;  // add x3,x2,x0
  localparam logic [31:0] I_LW5  = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] I_LW0  = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h00528333;  // add x6,x5,x5
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;  // beq x0,x0,-4

  initial begin
    int hold_cnt;
    logic [6:0] ops [12];
    logic [31:0] ins;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
    rst_n = 1'b0; instr_dat = 32'h0; f_in = '0; stall_in = 1'b0; w_in = '0;
    m_d_b = '0; m_d_nb = '0; m_bub = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;

    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reset_dout", d_b, 0);
    chk("reset_hold", hold_b, 0);

    // preload register file while fetch is stalled
    for (int i = 1; i < 32; i++)
      step(1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 5'(i), 32'h1000_0000 + 32'(i), 1'b0);

    // addi x1,x0,5 at pc 0
    step(1'b1, I_ADDI, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("addi_valid", d_b.valid, 1);
    chk("addi_cls", d_b.op_cls, OC_OP_IMM);
    chk("addi_imm", d_b.imm, 5);
    chk("addi_rd", d_b.rd, 1);
    chk("addi_rd_we", d_b.rd_we, 1);
    chk("addi_pc4", d_b.pc4, 32'h4);

    // same-cycle writeback x2 while reading x2
    step(1'b1, I_ADD3, 32'h8, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0);
    chk("byp_rs1", d_b.rs1_dat, 32'hDEADBEEF);
    chk("nobyp_rs1", d_nb.rs1_dat, 32'h1000_0002);
    step(1'b1, I_ADD3, 32'hC, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("nobyp_next", d_nb.rs1_dat, 32'hDEADBEEF);

    // load-use: lw x5 then add x6,x5,x5 (fetch re-presents add)
    hold_cnt = 0;
    step(1'b1, I_LW5, 32'h100, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lw_is_load", d_b.is_load, 1);
    step(1'b1, I_ADD6, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    hold_cnt += int'(obs_hold);
    chk("lu_bubble", d_b.valid, 0);
    step(1'b1, I_ADD6, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    hold_cnt += int'(obs_hold);
    step(1'b1, I_ADD6, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    hold_cnt += int'(obs_hold);
    chk("lu_add_valid", d_b.valid, 1);
    chk("lu_add_pc", d_b.pc, 32'h104);
    chk("lu_hold_cycles", 32'(hold_cnt), 1);

    // lw x0 causes no stall
    step(1'b1, I_LW0, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, I_ADD6, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("lw0_hold", obs_hold, 0);
    chk("lw0_add_valid", d_b.valid, 1);
    chk("lw0_add_pc", d_b.pc, 32'h204);

    // flush in the hazard-detect cycle
    step(1'b1, I_LW5, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, I_ADD6, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("flush_hold", obs_hold, 0);
    chk("flush_bubble", d_b.valid, 0);
    step(1'b1, I_ADDI, 32'h400, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("flush_next_valid", d_b.valid, 1);
    chk("flush_next_pc", d_b.pc, 32'h400);

    // immediates and illegal opcode
    step(1'b1, I_BEQ, 32'h404, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("beq_imm", d_b.imm, 32'hFFFFFFFC);
    chk("beq_cls", d_b.op_cls, OC_BRANCH);
    step(1'b1, 32'h0000007F, 32'h408, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("ill_flag", d_b.illegal, 1);
    chk("ill_rd_we", d_b.rd_we, 0);
    chk("ill_valid", d_b.valid, 1);

    // pc wrap and stall
    step(1'b1, I_ADDI, 32'hFFFFFFFC, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("wrap_pc4", d_b.pc4, 32'h0);
    step(1'b1, I_ADDI, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("stall_valid", d_b.valid, 0);

    // reset in the hazard-detect cycle
    step(1'b1, I_LW5, 32'h500, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b0, I_ADD6, 32'h504, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("rst_hold", obs_hold, 0);
    chk("rst_dout", d_b, 0);
    step(1'b1, I_ADDI, 32'h600, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("rst_next_valid", d_b.valid, 1);

    // randomized traffic, small register indices to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) ins[6:0] = 7'h03;
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) != 0), ins,
           ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage (s2_decode). Consumes the fetch stage's registered instruction address (`f_d_WI`) and raw instruction word, decodes RV32I, reads the 32×32 integer register file, and generates immediates. It detects load-use hazards and holds fetch for one cycle. It registers a decoded bundle (`d_e_WI`) for execute and accepts register-file writes from writeback.

## Interface
- `RF_BYPASS`, default 1: when 1, a writeback write to the register being read in the same cycle returns the write data.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `f_in` in `$bits(f_d_WI)`: from fetch; carries `instr_addr`.
- `instr_dat_in` in 32: instruction word, aligned with `f_in`.
- `stall_in` in 1: fetch bubble indicator; when high, the current `f_in`/`instr_dat_in` are invalid.
- `w_in` in `$bits(w_d_WI)`: writeback → decode. Fields: `rf_we`, `rd[4:0]`, `rd_dat[31:0]`, `jmp_tk`.
- `d_out` out `$bits(d_e_WI)`: registered decode bundle.
  - Fields: `valid`, `pc`, `pc4`, `rs1_dat`, `rs2_dat`, `imm`, `rs1`, `rs2`, `rd`, `op_cls[3:0]`, `funct3`, `funct7b5`, `is_load`, `rd_we`, `illegal`.
- `hold_out` out 1: combinational; drives the program counter's stall input. Asserted in the cycle a load-use hazard is detected.

## Operation
- **Input valid:** `in_v = ~stall_in & ~w_in.jmp_tk & (state==RUN)`.
- **Decode by opcode `[6:0]`:**
  - Classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC (FENCE/SYSTEM, decoded as NOP with `rd_we=0`).
  - Any other opcode, or `instr[1:0]!=2'b11`: `illegal=1`, `rd_we=0`, `valid=1`.
- **Immediates:** I, S, B, U, J formats, sign-extended to 32 bits. B/J have bit 0 = 0. U is `{instr[31:12],12'b0}`.
- **Register usage:**
  - `rs1` is used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - `rs2` is used by BRANCH, STORE, OP.
- **`rd_we`:** 1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and forced 0 when `rd==0`.
- **`pc4`:** `f_in.instr_addr + 4`, modulo 2^32 (wraps 0xFFFFFFFC → 0x00000000).
- **Register file:**
  - x0 reads 0 and writes to x0 are ignored.
  - Write occurs on the clock edge when `w_in.rf_we`.
  - Two combinational read ports with bypass per `RF_BYPASS`.
- **Load-use hazard:** `haz = in_v & d_out.valid & d_out.is_load & d_out.rd!=0 & ((rs1 used & rs1==d_out.rd) | (rs2 used & rs2==d_out.rd))`.
- **FSM states RUN and BUBBLE:**
  - RUN & `haz`: `hold_out=1`, register a bubble (`valid=0`), go to BUBBLE. Fetch re-presents the same instruction next cycle.
  - BUBBLE: `hold_out=0`, `in_v` forced 0, go to RUN. This cycle absorbs the fetch pipeline register's repeat.
  - RUN & no `haz`: register the decoded bundle with `valid=in_v`.
- **Flush:** `w_in.jmp_tk` registers a bubble, forces `hold_out=0`, and sets state to RUN. Flush overrides `haz` and BUBBLE.

## Timing
- **Reset:** `d_out` all zeros (`valid=0`), `hold_out=0`, state RUN. Register file contents are not reset.
- **Reset mid-hazard:** reset forces RUN next cycle and `hold_out=0` combinationally while `rst_n=0`.
- **Latency:** one cycle from `f_in`/`instr_dat_in` to `d_out`.
- **RF write vs. read:** a write in cycle N is visible to reads in cycle N (bypass) or N+1 (no bypass).
- **Load-use penalty:** exactly one bubble.
- **Throughput:** 1 instruction/cycle absent hazard, flush, or `stall_in`.
- **`stall_in` during BUBBLE:** no additional effect.

## Structure
- **Types package:** `d_e_WI` and `w_d_WI` structs, plus `op_cls` enum (`OC_LUI` … `OC_MISC`) and opcode localparams.
- **Shared library:** reuse the `d_register` pipeline register (`en=1`, `flush` = bubble condition) for `d_out`.
- **Sub-module `reg_file`:** 32×32, 2R1W, with bypass parameter.
- **Top level:** decode logic and FSM stay in the top module.

## Test plan
- **Reset, then `addi x1,x0,5` (0x00500093) at pc 0x0:** next cycle `valid=1`, `op_cls=OP_IMM`, `imm=5`, `rd=1`, `rd_we=1`, `pc4=0x4`.
- **Writeback x2=0xDEADBEEF same cycle as `add x3,x2,x0` decode:** `rs1_dat=0xDEADBEEF` with bypass; previous value without bypass.
- **`lw x5,0(x1)` then `add x6,x5,x5`:**
  - `hold_out=1` exactly one cycle.
  - One `valid=0` bubble.
  - `add` emitted next with correct `pc`.
  - Same `add` after `lw x0,...` causes no stall.
- **`w_in.jmp_tk` in the hazard-detect cycle:** `hold_out=0`, bubble registered, state RUN, following instruction decoded normally.
- **`beq` with imm −4 (0xFE000EE3):** `imm=0xFFFFFFFC`. Opcode 0x7F: `illegal=1`, `rd_we=0`.
- **pc 0xFFFFFFFC:** `pc4=0x0`. `stall_in=1` produces `valid=0`.
